// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer state type, opcode width and opcode constants shared by the control slice.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } seq_state_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 6'b010001;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_HALT   = 6'b111111;

    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: sequencer control/handshake bundle; master = sequencer, slave = datapath and memory.
interface multicycle_sequencer_if #(
    parameter int OPCODE_W = cpu_ctrl_pkg::OPCODE_W
);
    logic                start;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ack;
    logic                mem_req;
    logic                mem_we;
    logic                ir_load;
    logic                pc_en;
    logic                alu_en;
    logic                branch;
    logic                reg_we;
    logic                busy;
    logic                error;

    modport master (
        input  start, opcode, mem_ack,
        output mem_req, mem_we, ir_load, pc_en, alu_en, branch, reg_we, busy, error
    );

    modport slave (
        output start, opcode, mem_ack,
        input  mem_req, mem_we, ir_load, pc_en, alu_en, branch, reg_we, busy, error
    );

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: memory wait counter with terminal count, saturating at LIMIT.
// Compiled only when SEQ_TIMEOUT_EN is defined.
`ifdef SEQ_TIMEOUT_EN
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb control FSM owning the shared memory handshake.
// Memory timeout with a sticky error flag is built only when SEQ_TIMEOUT_EN is defined.
module multicycle_sequencer #(
    parameter int OPCODE_W    = cpu_ctrl_pkg::OPCODE_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_sequencer_if.master bus
);
    import cpu_ctrl_pkg::*;

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [OPCODE_W-1:0] r_op;
    logic                w_wait;
    logic                w_timeout;
    logic                w_error;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);

`ifdef SEQ_TIMEOUT_EN
    logic w_tc;
    logic r_error;

    // Counter is held clear outside FETCH/MEM and on the ack edge, so it is zero on every entry.
    mem_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk  (clk),
        .reset(reset),
        .i_clr(!w_wait || bus.mem_ack),
        .i_inc(w_wait && !bus.mem_ack),
        .o_tc (w_tc)
    );

    assign w_timeout = w_wait && w_tc && !bus.mem_ack;
    assign w_error   = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_error <= 1'b0;
        else if (w_timeout)
            r_error <= 1'b1;
    end
`else
    logic w_unused_limit;

    assign w_unused_limit = |TIMEOUT_CYC;
    assign w_timeout      = 1'b0;
    assign w_error        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= bus.opcode;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (bus.start && !w_error) ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = bus.mem_ack ? S_DECODE : (w_timeout ? S_IDLE : S_FETCH);
            S_DECODE: w_next = (bus.opcode == OP_HALT) ? S_IDLE : S_EXEC;
            S_EXEC:   w_next = (r_op == OP_BRANCH) ? S_FETCH : (is_mem_op(r_op) ? S_MEM : S_WB);
            S_MEM:    w_next = bus.mem_ack ? ((r_op == OP_STORE) ? S_FETCH : S_WB)
                                           : (w_timeout ? S_IDLE : S_MEM);
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    assign bus.mem_req = w_wait;
    assign bus.mem_we  = (r_state == S_MEM) && (r_op == OP_STORE);
    assign bus.ir_load = (r_state == S_FETCH) && bus.mem_ack;
    assign bus.pc_en   = (r_state == S_DECODE);
    assign bus.alu_en  = (r_state == S_EXEC) && (r_op != OP_BRANCH);
    assign bus.branch  = (r_state == S_EXEC) && (r_op == OP_BRANCH);
    assign bus.reg_we  = (r_state == S_WB);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.error   = w_error;

endmodule
